// File: rtl/clarke_transform_if.sv
// Bus bundle for the Clarke transform.
//   a, b   : signed phase samples, presented by the producer
//   start  : input-valid qualifier for a/b
//   alpha  : stationary-frame alpha (delayed a)
//   beta   : stationary-frame beta, (a + 2b)/sqrt(3), rounded and saturated
//   done   : output-valid, one pulse per accepted start
// master = producer/consumer side, slave = the transform block.
interface clarke_transform_if #(
  parameter int D_WIDTH = 18
) ();
  logic signed [D_WIDTH-1:0] a;
  logic signed [D_WIDTH-1:0] b;
  logic                      start;
  logic signed [D_WIDTH-1:0] alpha;
  logic signed [D_WIDTH-1:0] beta;
  logic                      done;

  modport master (
    output a, b, start,
    input  alpha, beta, done
  );

  modport slave (
    input  a, b, start,
    output alpha, beta, done
  );
endinterface

// File: rtl/clarke_transform.sv
// Pipelined fixed-point Clarke transform.
//   alpha = a
//   beta  = (a + 2b)/sqrt(3) = a*K1 + b*K2, rescaled by 2^-Q_BITS
// Two register stages: products, then round/saturate into the outputs.
// One sample per clock, no backpressure.
// Ports:
//   clk  : clock, rising edge
//   rstb : asynchronous, active-high reset; clears every pipeline register
//   bus  : clarke_transform_if.slave (a, b, start in; alpha, beta, done out)
// Q_BITS must not exceed D_WIDTH-3.
module clarke_transform #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15
) (
  input  logic                  clk,
  input  logic                  rstb,
  clarke_transform_if.slave     bus
);

  localparam int  PW        = 2 * D_WIDTH;
  localparam real INV_SQRT3 = 0.57735026918962576;

  // Rounded scale constants: K1 = 2^Q/sqrt3, K2 = 2^(Q+1)/sqrt3.
  localparam int K1_INT = $rtoi(real'(2 ** Q_BITS) * INV_SQRT3 + 0.5);
  localparam int K2_INT = $rtoi(real'(2 ** (Q_BITS + 1)) * INV_SQRT3 + 0.5);

  localparam logic [D_WIDTH-1:0] K1 = D_WIDTH'(K1_INT);
  localparam logic [D_WIDTH-1:0] K2 = D_WIDTH'(K2_INT);

  // Zero-extended so the unsigned constants multiply as positive signed values.
  localparam logic signed [PW-1:0] K1_EXT = {{D_WIDTH{1'b0}}, K1};
  localparam logic signed [PW-1:0] K2_EXT = {{D_WIDTH{1'b0}}, K2};

  localparam logic signed [PW:0] RND_HALF =
    {{(PW + 1 - Q_BITS){1'b0}}, 1'b1, {(Q_BITS - 1){1'b0}}};
  localparam logic signed [PW:0] SAT_MAX =
    {{(D_WIDTH + 2){1'b0}}, {(D_WIDTH - 1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN =
    {{(D_WIDTH + 2){1'b1}}, {(D_WIDTH - 1){1'b0}}};

  // Round half toward +inf, then drop the fractional bits.
  function automatic logic signed [PW:0] round_shift(input logic signed [PW:0] s);
    logic signed [PW:0] t;
    t = s + RND_HALF;
    return t >>> Q_BITS;
  endfunction

  function automatic logic signed [D_WIDTH-1:0] saturate(input logic signed [PW:0] r);
    logic signed [D_WIDTH-1:0] y;
    if (r > SAT_MAX)
      y = {1'b0, {(D_WIDTH - 1){1'b1}}};
    else if (r < SAT_MIN)
      y = {1'b1, {(D_WIDTH - 1){1'b0}}};
    else
      y = r[D_WIDTH-1:0];
    return y;
  endfunction

  // Inputs sign-extended to product width; the product then needs no widening.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  assign a_ext = {{D_WIDTH{bus.a[D_WIDTH-1]}}, bus.a};
  assign b_ext = {{D_WIDTH{bus.b[D_WIDTH-1]}}, bus.b};

  logic signed [PW-1:0]      prod_a_p1;
  logic signed [PW-1:0]      prod_b_p1;
  logic signed [D_WIDTH-1:0] alpha_p1;
  logic                      vld_p1;

  logic signed [PW:0]        sum_p1;

  logic signed [D_WIDTH-1:0] alpha_p2;
  logic signed [D_WIDTH-1:0] beta_p2;
  logic                      vld_p2;

  // Stage 1: full-precision products and alpha delay.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      prod_a_p1 <= '0;
      prod_b_p1 <= '0;
      alpha_p1  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      prod_a_p1 <= a_ext * K1_EXT;
      prod_b_p1 <= b_ext * K2_EXT;
      alpha_p1  <= bus.a;
      vld_p1    <= bus.start;
    end
  end

  // One guard bit so the sum of two full-scale products cannot wrap.
  assign sum_p1 = {prod_a_p1[PW-1], prod_a_p1} + {prod_b_p1[PW-1], prod_b_p1};

  // Stage 2: round, saturate, register outputs.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      alpha_p2 <= '0;
      beta_p2  <= '0;
      vld_p2   <= 1'b0;
    end else begin
      alpha_p2 <= alpha_p1;
      beta_p2  <= saturate(round_shift(sum_p1));
      vld_p2   <= vld_p1;
    end
  end

  assign bus.alpha = alpha_p2;
  assign bus.beta  = beta_p2;
  assign bus.done  = vld_p2;

endmodule

// File: tb/tb_clarke_transform.sv
// Directed bench for clarke_transform (D_WIDTH=18, Q_BITS=15).
module tb_clarke_transform;

  localparam int DW = 18;
  localparam int QB = 15;

  logic clk;
  logic rstb;

  clarke_transform_if #(.D_WIDTH(DW)) bus ();

  clarke_transform #(.D_WIDTH(DW), .Q_BITS(QB)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    a;
    int    b;
    int    alpha_exp;
    int    beta_exp;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  int n_checks;
  int n_fail;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic drive(input int a, input int b, input logic st);
    bus.a     = DW'(a);
    bus.b     = DW'(b);
    bus.start = st;
  endtask

  // One isolated sample: present, then check exactly two edges later.
  task automatic run_single(input vec_t v);
    @(negedge clk);
    drive(v.a, v.b, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    chk({v.nm, " done_early"}, int'(bus.done), 0);
    @(negedge clk);
    chk({v.nm, " done"},  int'(bus.done), 1);
    chk({v.nm, " alpha"}, int'(bus.alpha), v.alpha_exp);
    chk({v.nm, " beta"},  int'(bus.beta),  v.beta_exp);
    @(negedge clk);
    chk({v.nm, " done_drop"}, int'(bus.done), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // beta expectations: floor((a*18919 + b*37837 + 16384) / 32768), clamped
    tbl[0]  = '{"v_pos",      27427,   3310,   27427,   19657};
    tbl[1]  = '{"v_mix",     -30376,  22970,  -30376,    8985};
    tbl[2]  = '{"v_neg",     -20683, -14752,  -20683,  -28976};
    tbl[3]  = '{"v_m1",      -32768, -32768,  -32768,  -56756};
    tbl[4]  = '{"sat_pos",   131071, 131071,  131071,  131071};
    tbl[5]  = '{"sat_neg",  -131072,-131072, -131072, -131072};
    tbl[6]  = '{"zero",           0,      0,       0,       0};
    tbl[7]  = '{"a_lsb",          1,      0,       1,       1};
    tbl[8]  = '{"a_mlsb",        -1,      0,      -1,      -1};
    tbl[9]  = '{"b_lsb",          0,      1,       0,       1};
    tbl[10] = '{"a_minonly", -131072,     0, -131072,  -75676};
    tbl[11] = '{"b_minonly",      0,-131072,       0, -131072};

    rstb = 1'b1;
    drive(0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst alpha", int'(bus.alpha), 0);
    chk("rst beta",  int'(bus.beta),  0);
    chk("rst done",  int'(bus.done),  0);
    rstb = 1'b0;

    for (int i = 0; i < NV; i++) run_single(tbl[i]);

    // Back-to-back stream of the first four vectors.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("b2b done_early", int'(bus.done), 0);
      if (k >= 2) begin
        chk($sformatf("b2b%0d done", k - 2),  int'(bus.done), 1);
        chk($sformatf("b2b%0d alpha", k - 2), int'(bus.alpha), tbl[k-2].alpha_exp);
        chk($sformatf("b2b%0d beta", k - 2),  int'(bus.beta),  tbl[k-2].beta_exp);
      end
      if (k < 4) drive(tbl[k].a, tbl[k].b, 1'b1);
      else       drive(0, 0, 1'b0);
    end
    @(negedge clk);
    chk("b2b done_end", int'(bus.done), 0);

    // Reset mid-stream: first sample on outputs, second in stage 1.
    @(negedge clk);
    drive(tbl[4].a, tbl[4].b, 1'b1);
    @(negedge clk);
    drive(tbl[0].a, tbl[0].b, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    chk("pre_rst done", int'(bus.done), 1);
    rstb = 1'b1;
    #1;
    chk("async_rst alpha", int'(bus.alpha), 0);
    chk("async_rst beta",  int'(bus.beta),  0);
    chk("async_rst done",  int'(bus.done),  0);
    @(negedge clk);
    rstb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst done%0d", k), int'(bus.done), 0);
    end

    // First start straight after reset release is accepted.
    run_single(tbl[1]);

    // Idle: start held low.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle done%0d", k), int'(bus.done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clarke_transform.md
# clarke_transform

Pipelined fixed-point Clarke transform for the motor-control datapath. It converts two signed phase samples (a, b; the third phase is implied by a + b + c = 0) into stationary-frame components: alpha = a, beta = (a + 2b)/√3. It sits between the phase-current ADC scaling stage and the Park transform. It accepts one sample per clock.

## Interface
- D_WIDTH, default 18: signed two's-complement width of all data ports.
- Q_BITS, default 15: number of fractional bits, so 1.0 = 2^Q_BITS. Requires Q_BITS ≤ D_WIDTH−3.
- clk  in  1  clock; all state updates on the rising edge.
- rstb  in  1  reset, asynchronous, active-high.
- a  in  D_WIDTH  phase-A sample, signed Q(D_WIDTH−Q_BITS−1).Q_BITS.
- b  in  D_WIDTH  phase-B sample, same format as a.
- start  in  1  input-valid qualifier; a and b are sampled on every rising edge where start=1.
- alpha  out  D_WIDTH  alpha result, signed, same Q format as the inputs.
- beta  out  D_WIDTH  beta result, signed, same Q format as the inputs.
- done  out  1  output-valid; high for exactly one cycle per accepted start.

## Operation
- Constants are computed at elaboration:
  - K1 = round(2^Q_BITS/√3). For Q=15 this gives 18919.
  - K2 = round(2^(Q_BITS+1)/√3). For Q=15 this gives 37837.
  - Both are held as unsigned constants of D_WIDTH bits.
- Stage 1, on start:
  - Register p1 = a·K1 and p2 = b·K2 as full-precision signed products (2·D_WIDTH bits).
  - Register a into an alpha delay register.
  - Register valid1 = start.
- Stage 2:
  - s = p1 + p2, computed 1 bit wider than the products.
  - r = (s + 2^(Q_BITS−1)) >>> Q_BITS. This is arithmetic shift with round-half-up.
  - Saturate r to [−2^(D_WIDTH−1), 2^(D_WIDTH−1)−1].
  - Register the result to beta, the delayed a to alpha, and valid1 to done.
- alpha is a pure delay of a and is never modified.
- No FSM. The block is a fully pipelined 2-stage datapath with a valid shift register.
- When start=0, the data registers may load don't-care values. Outputs are only meaningful when done=1. Pipeline registers carry no enables beyond the valid bit.

## Timing
- Latency is 2 cycles. Inputs sampled at rising edge N (with start=1) appear on alpha and beta, with done=1, after edge N+2.
- Throughput is 1 sample per cycle. Back-to-back start=1 yields back-to-back done=1, in order, with no bubbles.
- There is no backpressure. The consumer must accept every done pulse.
- Reset (rstb=1) asynchronously clears all pipeline registers. alpha=0, beta=0 and done=0 immediately.
  - Samples in flight when reset asserts are discarded; no done is issued for them.
  - After reset deasserts, the first start is accepted on the next rising edge.
- Boundary conditions:
  - Saturation applies only to beta. For the positive clamp, beta = 2^(D_WIDTH−1)−1. For the negative clamp, beta = −2^(D_WIDTH−1).
  - The most-negative input (−2^(D_WIDTH−1)) on a or b must not overflow the internal products.

## Test plan
- Reset: assert rstb mid-stream with two samples in flight -> alpha=0, beta=0, done=0 immediately; no done pulse follows for the discarded samples.
- Single sample (D=18, Q=15): a=27427 (0.837), b=3310 (0.101) -> 2 cycles later done=1, alpha=27427, beta=19657.
- Back-to-back stream of four consecutive start cycles:
  - Inputs, in order: (27427, 3310); (−30376, 22970); (−20683, −14752); (−32768, −32768).
  - Required response: done high for 4 consecutive cycles.
  - Outputs in order: beta=19657, then 8985, then expected per the formula, then −56756.
- Positive saturation: a=b=131071 -> beta=131071, alpha=131071.
- Negative saturation: a=b=−131072 -> beta=−131072, alpha=−131072.
- Zero and idle: a=b=0 with start=1 -> alpha=0, beta=0. With start held at 0, done stays 0 indefinitely.
